// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared constants for the multi-cycle control unit: FSM state codes,
// instruction opcodes (IR[31:26]), ALUOp encodings, PCSrc and RegDst
// selector codes, plus small opcode-class helpers used by the decoder
// and the next-state logic.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_XORI  = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_REG    = 2'd2;
  localparam logic [1:0] PC_JUMP   = 2'd3;

  localparam logic [1:0] RD_RA = 2'd0;
  localparam logic [1:0] RD_RT = 2'd1;
  localparam logic [1:0] RD_RD = 2'd2;

  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI,
      OP_ORI, OP_XORI, OP_SLL, OP_SLTI: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // R-type ALU ops write rd; the immediate forms write rt.
  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_SLL);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
  endfunction

  function automatic logic is_ls(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_LW);
  endfunction

  function automatic logic uses_imm(input logic [5:0] op);
    case (op)
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SW, OP_LW: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: return ALU_SUB;
      OP_AND, OP_ANDI:                 return ALU_AND;
      OP_ORI:                          return ALU_OR;
      OP_XORI:                         return ALU_XOR;
      OP_SLL:                          return ALU_SLL;
      OP_SLTI:                         return ALU_SLT;
      default:                         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode
// Purely combinational output decode: (state, opcode, zero, sign) to all
// datapath enables and selects. No reset handling here; the top gates the
// write/strobe outputs while Rst is high.
// Inputs : state, opcode[5:0], zero, sign
// Outputs: PCWre, PCSrc[1:0], IRWre, InsMemRW, RegWre, RegDst[1:0],
//          WrRegDSrc, ALUSrcA, ALUSrcB, ALUOp[2:0], ExtSel, mRD, mWR, DBDataSrc
import mc_ctrl_pkg::*;

module mc_ctrl_decode (
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        sign,
  output logic        PCWre,
  output logic [1:0]  PCSrc,
  output logic        IRWre,
  output logic        InsMemRW,
  output logic        RegWre,
  output logic [1:0]  RegDst,
  output logic        WrRegDSrc,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        ExtSel,
  output logic        mRD,
  output logic        mWR,
  output logic        DBDataSrc
);

  logic ends_in_id;
  logic br_taken;

  // Jumps, undefined opcodes (but not halt) retire in ID.
  assign ends_in_id = !is_alu_op(opcode) && !is_branch(opcode) &&
                      !is_ls(opcode) && (opcode != OP_HALT);

  assign br_taken = ((opcode == OP_BEQ)  &&  zero) ||
                    ((opcode == OP_BNE)  && !zero) ||
                    ((opcode == OP_BLTZ) &&  sign);

  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = PC_SEQ;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    RegDst    = RD_RA;
    WrRegDSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;

    // IR still holds the previous instruction during IF, so the ALU
    // controls are driven from opcode only after it has been loaded.
    // They stay constant through every later state of the instruction.
    if (state != S_IF) begin
      ALUOp   = alu_op_of(opcode);
      ALUSrcA = (opcode == OP_SLL);
      ALUSrcB = uses_imm(opcode);
      ExtSel  = !((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI));
    end

    case (state)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end
      S_ID: begin
        PCWre = ends_in_id;
        if ((opcode == OP_J) || (opcode == OP_JAL)) PCSrc = PC_JUMP;
        else if (opcode == OP_JR)                   PCSrc = PC_REG;
        if (opcode == OP_JAL) begin
          RegWre    = 1'b1;
          RegDst    = RD_RA;
          WrRegDSrc = 1'b0;
        end
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        if (br_taken) PCSrc = PC_BRANCH;
      end
      S_WB_AL: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        RegDst    = is_rtype(opcode) ? RD_RD : RD_RT;
        WrRegDSrc = 1'b1;
      end
      S_MEM: begin
        if (opcode == OP_SW) begin
          mWR   = 1'b1;
          PCWre = 1'b1;
        end else if (opcode == OP_LW) begin
          mRD = 1'b1;
        end
      end
      S_WB_LD: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        RegDst    = RD_RT;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b1;
        mRD       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit
// Multi-cycle CPU control unit. Holds the state register and next-state
// logic; output decode lives in mc_ctrl_decode.
// Inputs : CLK, Rst (sync, active-high), opcode[5:0], zero, sign
// Outputs: PC/IR/regfile/memory enables and datapath selects, state[2:0]
//
// state   | meaning
// IF      | fetch: read imem, load IR
// ID      | decode; jumps/undefined retire here, halt parks here
// EXE_LS  | address calc for lw/sw
// MEM     | data memory access (sw retires)
// WB_LD   | load writeback
// EXE_BR  | branch compare and PC update
// EXE_AL  | ALU execute
// WB_AL   | ALU writeback
import mc_ctrl_pkg::*;

module mc_control_unit (
  input  logic        CLK,
  input  logic        Rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        sign,
  output logic        PCWre,
  output logic [1:0]  PCSrc,
  output logic        IRWre,
  output logic        InsMemRW,
  output logic        RegWre,
  output logic [1:0]  RegDst,
  output logic        WrRegDSrc,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        ExtSel,
  output logic        mRD,
  output logic        mWR,
  output logic        DBDataSrc,
  output logic [2:0]  state
);

  state_t state_q, state_d;

  logic dec_pcwre, dec_irwre, dec_insmemrw, dec_regwre, dec_mrd, dec_mwr;

  always_ff @(posedge CLK) begin
    if (Rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_alu_op(opcode))      state_d = S_EXE_AL;
        else if (is_branch(opcode)) state_d = S_EXE_BR;
        else if (is_ls(opcode))     state_d = S_EXE_LS;
        else if (opcode == OP_HALT) state_d = S_ID;
        else                        state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
      default:  state_d = S_IF;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .sign      (sign),
    .PCWre     (dec_pcwre),
    .PCSrc     (PCSrc),
    .IRWre     (dec_irwre),
    .InsMemRW  (dec_insmemrw),
    .RegWre    (dec_regwre),
    .RegDst    (RegDst),
    .WrRegDSrc (WrRegDSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ExtSel    (ExtSel),
    .mRD       (dec_mrd),
    .mWR       (dec_mwr),
    .DBDataSrc (DBDataSrc)
  );

  // Anything that writes state elsewhere is suppressed during reset so an
  // abandoned instruction never commits.
  assign PCWre    = dec_pcwre    & ~Rst;
  assign IRWre    = dec_irwre    & ~Rst;
  assign InsMemRW = dec_insmemrw & ~Rst;
  assign RegWre   = dec_regwre   & ~Rst;
  assign mRD      = dec_mrd      & ~Rst;
  assign mWR      = dec_mwr      & ~Rst;

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  logic       CLK = 1'b0;
  logic       Rst;
  logic [5:0] opcode;
  logic       zero, sign;
  logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB;
  logic       ExtSel, mRD, mWR, DBDataSrc;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, state;

  always #5 CLK = ~CLK;

  mc_control_unit dut (
    .CLK(CLK), .Rst(Rst), .opcode(opcode), .zero(zero), .sign(sign),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .state(state)
  );

  // wr = {PCWre, IRWre, InsMemRW, RegWre, mRD, mWR}
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z, s;
    logic [2:0] st;
    logic [5:0] wr;
    logic [1:0] pcsrc, regdst;
    logic       wrsrc, dbsrc;
    logic       chk_alu;
    logic [2:0] aluop;
    logic       srca, srcb, ext;
  } vec_t;

  localparam logic [5:0] W_NONE = 6'b000000, W_IF = 6'b011000, W_PC = 6'b100000;
  localparam logic [5:0] W_WBAL = 6'b100100, W_MEMLW = 6'b000010;
  localparam logic [5:0] W_WBLD = 6'b100110, W_SW = 6'b100001;

  int n_chk = 0;
  int n_fail = 0;
  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic [5:0] op, logic z, logic s,
                              logic [2:0] st, logic [5:0] wr, logic [1:0] pcsrc,
                              logic [1:0] regdst, logic wrsrc, logic dbsrc,
                              logic chk_alu, logic [2:0] aluop,
                              logic srca, logic srcb, logic ext);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.s = s; v.st = st; v.wr = wr;
    v.pcsrc = pcsrc; v.regdst = regdst; v.wrsrc = wrsrc; v.dbsrc = dbsrc;
    v.chk_alu = chk_alu; v.aluop = aluop; v.srca = srca; v.srcb = srcb; v.ext = ext;
    return v;
  endfunction

  // IF: fetch strobes only, every select at 0 regardless of opcode
  function automatic vec_t v_if(logic [5:0] op);
    return mk(0, op, 0, 0, 3'd0, W_IF, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0);
  endfunction
  function automatic vec_t v_id(logic [5:0] op);
    return mk(0, op, 0, 0, 3'd1, W_NONE, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
  endfunction
  function automatic void alu_instr(logic [5:0] op, logic [2:0] aop, logic a,
                                    logic b, logic e, logic [1:0] rd);
    vq.push_back(v_if(op));
    vq.push_back(v_id(op));
    vq.push_back(mk(0, op, 0, 0, 3'd6, W_NONE, 0, 0, 0, 0, 1, aop, a, b, e));
    vq.push_back(mk(0, op, 0, 0, 3'd7, W_WBAL, 0, rd, 1, 0, 1, aop, a, b, e));
  endfunction
  function automatic void br_instr(logic [5:0] op, logic z, logic s, logic [1:0] pcs);
    vq.push_back(v_if(op));
    vq.push_back(mk(0, op, z, s, 3'd1, W_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, op, z, s, 3'd5, W_PC, pcs, 0, 0, 0, 1, 3'b001, 0, 0, 1));
  endfunction
  function automatic void id_instr(logic [5:0] op, logic [5:0] wr, logic [1:0] pcs);
    vq.push_back(v_if(op));
    vq.push_back(mk(0, op, 0, 0, 3'd1, wr, pcs, 2'd0, 0, 0, 0, 0, 0, 0, 0));
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [5:0] wr_now();
    return {PCWre, IRWre, InsMemRW, RegWre, mRD, mWR};
  endfunction

  initial begin
    int cyc, rw_cnt, rd_cnt;
    Rst = 1'b1; opcode = 6'b000000; zero = 1'b0; sign = 1'b0;

    // ---- reset held for two cycles ----
    @(negedge CLK); #1;
    chk("rst_state", -1, 8'(state), 8'd0);
    chk("rst_wr", -1, 8'(wr_now()), 8'd0);
    @(negedge CLK); #1;
    chk("rst_wr2", -2, 8'(wr_now()), 8'd0);

    // ---- table ----
    alu_instr(6'b000000, 3'b000, 0, 0, 1, 2'd2);   // add
    alu_instr(6'b010001, 3'b100, 0, 1, 0, 2'd1);   // andi
    alu_instr(6'b011000, 3'b010, 1, 0, 1, 2'd2);   // sll
    alu_instr(6'b100110, 3'b101, 0, 1, 1, 2'd1);   // slti
    alu_instr(6'b000001, 3'b001, 0, 0, 1, 2'd2);   // sub
    alu_instr(6'b010011, 3'b111, 0, 1, 0, 2'd1);   // xori
    // lw
    vq.push_back(v_if(6'b110001));
    vq.push_back(v_id(6'b110001));
    vq.push_back(mk(0, 6'b110001, 0, 0, 3'd2, W_NONE,  0, 0, 0, 0, 1, 3'b000, 0, 1, 1));
    vq.push_back(mk(0, 6'b110001, 0, 0, 3'd3, W_MEMLW, 0, 0, 0, 0, 1, 3'b000, 0, 1, 1));
    vq.push_back(mk(0, 6'b110001, 0, 0, 3'd4, W_WBLD,  0, 1, 1, 1, 1, 3'b000, 0, 1, 1));
    // sw
    vq.push_back(v_if(6'b110000));
    vq.push_back(v_id(6'b110000));
    vq.push_back(mk(0, 6'b110000, 0, 0, 3'd2, W_NONE, 0, 0, 0, 0, 1, 3'b000, 0, 1, 1));
    vq.push_back(mk(0, 6'b110000, 0, 0, 3'd3, W_SW,   0, 0, 0, 0, 1, 3'b000, 0, 1, 1));
    // branches
    br_instr(6'b110100, 1, 0, 2'd1);   // beq taken
    br_instr(6'b110100, 0, 0, 2'd0);   // beq not taken
    br_instr(6'b110101, 0, 0, 2'd1);   // bne taken
    br_instr(6'b110101, 1, 1, 2'd0);   // bne not taken
    br_instr(6'b110110, 0, 1, 2'd1);   // bltz taken
    br_instr(6'b110110, 1, 0, 2'd0);   // bltz not taken
    // jumps and undefined
    id_instr(6'b111010, W_WBAL, 2'd3); // jal
    id_instr(6'b111000, W_PC,   2'd3); // j
    id_instr(6'b111001, W_PC,   2'd2); // jr
    id_instr(6'b101010, W_PC,   2'd0); // undefined
    // halt for 10 cycles, then reset
    vq.push_back(v_if(6'b111111));
    for (int k = 0; k < 10; k++) vq.push_back(v_id(6'b111111));
    vq.push_back(mk(1, 6'b111111, 0, 0, 3'd1, W_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // sw abandoned by reset in MEM
    vq.push_back(v_if(6'b110000));
    vq.push_back(v_id(6'b110000));
    vq.push_back(mk(0, 6'b110000, 0, 0, 3'd2, W_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 6'b110000, 0, 0, 3'd3, W_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(v_if(6'b110000));
    vq.push_back(v_id(6'b110000));

    foreach (vq[i]) begin
      @(negedge CLK);
      Rst = vq[i].rst; opcode = vq[i].op; zero = vq[i].z; sign = vq[i].s;
      #1;
      chk("state", i, 8'(state), 8'(vq[i].st));
      chk("wr_strobes", i, 8'(wr_now()), 8'(vq[i].wr));
      if (!vq[i].rst) chk("PCSrc", i, 8'(PCSrc), 8'(vq[i].pcsrc));
      if (vq[i].wr[2]) begin
        chk("RegDst", i, 8'(RegDst), 8'(vq[i].regdst));
        chk("WrRegDSrc", i, 8'(WrRegDSrc), 8'(vq[i].wrsrc));
        chk("DBDataSrc", i, 8'(DBDataSrc), 8'(vq[i].dbsrc));
      end
      if (vq[i].chk_alu) begin
        chk("ALUOp", i, 8'(ALUOp), 8'(vq[i].aluop));
        chk("ALUSrcA", i, 8'(ALUSrcA), 8'(vq[i].srca));
        chk("ALUSrcB", i, 8'(ALUSrcB), 8'(vq[i].srcb));
        chk("ExtSel", i, 8'(ExtSel), 8'(vq[i].ext));
      end
    end

    // ---- lw latency: IF entry to next IF entry, bounded ----
    @(negedge CLK); Rst = 1'b1; opcode = 6'b110001; zero = 0; sign = 0;
    @(negedge CLK); Rst = 1'b0; #1;
    chk("lw_start_if", 900, 8'(state), 8'd0);
    cyc = 0; rw_cnt = 0; rd_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      if (RegWre) rw_cnt++;
      if (mRD) rd_cnt++;
      @(negedge CLK); #1;
      if (state == 3'd0) begin cyc = k; break; end
    end
    chk("lw_latency", 901, 8'(cyc), 8'd5);
    chk("lw_regwre_pulses", 902, 8'(rw_cnt), 8'd1);
    chk("lw_mrd_cycles", 903, 8'(rd_cnt), 8'd2);

    // ---- reset during WB_AL of add: no register write ----
    @(negedge CLK); Rst = 1'b1; opcode = 6'b000000;
    @(negedge CLK); Rst = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("add_in_wbal", 910, 8'(state), 8'd7);
    Rst = 1'b1; #1;
    chk("wbal_rst_regwre", 911, 8'(RegWre), 8'd0);
    chk("wbal_rst_pcwre", 912, 8'(PCWre), 8'd0);
    @(negedge CLK); Rst = 1'b0; #1;
    chk("wbal_rst_to_if", 913, 8'(state), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
